// File: rtl/avalon_st_pkt_arbiter_if.sv
// ---------------------------------------------------------------------------
// avalon_st_pkt_arbiter_if
// Bundle of the N Avalon-ST source streams and the single merged sink stream
// handled by avalon_st_pkt_arbiter.
//   master : traffic side (drives source beats and sink ready)
//   slave  : the arbiter (drives source ready and the merged sink stream)
// Signals:
//   in_data/in_valid/in_startofpacket/in_endofpacket/in_empty : N source streams
//   in_ready                                                 : per-source ready
//   out_data/out_valid/out_startofpacket/out_endofpacket/out_empty : merged sink
//   out_ready   : sink ready
//   out_channel : index of the granted source
//   sop_err     : one-cycle pulse after a stray non-SOP beat was discarded
// ---------------------------------------------------------------------------
interface avalon_st_pkt_arbiter_if #(
  parameter int N       = 4,
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 5,
  parameter int CH_W    = 2
);
  logic [N*DATA_W-1:0]  in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N-1:0]         in_startofpacket;
  logic [N-1:0]         in_endofpacket;
  logic [N*EMPTY_W-1:0] in_empty;
  logic [DATA_W-1:0]    out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_startofpacket;
  logic                 out_endofpacket;
  logic [EMPTY_W-1:0]   out_empty;
  logic [CH_W-1:0]      out_channel;
  logic                 sop_err;

  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
    input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket,
           out_empty, out_channel, sop_err
  );

  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket, in_empty, out_ready,
    output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket,
           out_empty, out_channel, sop_err
  );
endinterface

// File: rtl/avalon_st_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_st_pkt_arbiter
// Packet-atomic round-robin arbiter merging N Avalon-ST sources onto one sink.
// A grant is taken on a start-of-packet beat and held until the end-of-packet
// beat transfers, so packets are never interleaved. Each packet costs one
// arbitration cycle (no beat moves while arbitrating).
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : avalon_st_pkt_arbiter_if.slave (sources, merged sink, channel,
//           sop_err)
// ---------------------------------------------------------------------------
module avalon_st_pkt_arbiter #(
  parameter int N       = 4,
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 5,
  parameter int CH_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  avalon_st_pkt_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   g_q, g_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              sop_err_q, sop_err_d;

  logic [N-1:0]      req_s;
  logic [N-1:0]      stray_s;
  logic [2*N-1:0]    req_dbl_s;
  logic [N-1:0]      rot_s;
  logic              found_s;
  logic [CH_W-1:0]   win_s;

  logic [N-1:0]      sel_s;
  logic [DATA_W-1:0] g_data_s;
  logic              g_valid_s;
  logic              g_sop_s;
  logic              g_eop_s;
  logic [EMPTY_W-1:0] g_empty_s;
  logic              xfer_s;

  // Classify source beats and rotate the request vector so ptr sits at bit 0.
  always_comb begin
    req_s     = bus.in_valid & bus.in_startofpacket;
    stray_s   = bus.in_valid & ~bus.in_startofpacket;
    req_dbl_s = {req_s, req_s} >> ptr_q;
    rot_s     = req_dbl_s[N-1:0];
  end

  // Round-robin winner: lowest set bit of the rotated vector, mapped back to a
  // stream index modulo N.
  always_comb begin
    int off;
    int win;
    off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      off = rot_s[k] ? k : off;
    end
    win     = int'(ptr_q) + off;
    win     = (win >= N) ? (win - N) : win;
    found_s = |rot_s;
    win_s   = win[CH_W-1:0];
  end

  // Select the granted stream with an AND-OR mux on a decoded grant.
  always_comb begin
    sel_s     = '0;
    g_data_s  = '0;
    g_valid_s = 1'b0;
    g_sop_s   = 1'b0;
    g_eop_s   = 1'b0;
    g_empty_s = '0;
    for (int i = 0; i < N; i++) begin
      sel_s[i]  = (g_q == CH_W'(i));
      g_data_s  = g_data_s  | (bus.in_data[i*DATA_W +: DATA_W] & {DATA_W{sel_s[i]}});
      g_empty_s = g_empty_s | (bus.in_empty[i*EMPTY_W +: EMPTY_W] & {EMPTY_W{sel_s[i]}});
      g_valid_s = g_valid_s | (bus.in_valid[i] & sel_s[i]);
      g_sop_s   = g_sop_s   | (bus.in_startofpacket[i] & sel_s[i]);
      g_eop_s   = g_eop_s   | (bus.in_endofpacket[i] & sel_s[i]);
    end
  end

  assign xfer_s = (state_q == LOCK) && g_valid_s && bus.out_ready;

  // State, grant, pointer and error-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      g_q       <= '0;
      ptr_q     <= '0;
      sop_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      sop_err_q <= sop_err_d;
    end
  end

  // Next-state logic: grant on a winner, release after the EOP transfer.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    sop_err_d = 1'b0;
    case (state_q)
      ARB: begin
        // Any number of simultaneous strays collapses into one pulse.
        sop_err_d = |stray_s;
        if (found_s) begin
          state_d = LOCK;
          g_d     = win_s;
        end else begin
          state_d = ARB;
        end
      end
      LOCK: begin
        if (xfer_s && g_eop_s) begin
          state_d = ARB;
          ptr_d   = ((int'(g_q) + 1) >= N) ? '0 : (g_q + CH_W'(1));
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Outputs: drain strays while arbitrating, pass the granted stream through
  // while locked.
  always_comb begin
    bus.in_ready          = '0;
    bus.out_data          = '0;
    bus.out_valid         = 1'b0;
    bus.out_startofpacket = 1'b0;
    bus.out_endofpacket   = 1'b0;
    bus.out_empty         = '0;
    bus.out_channel       = '0;
    case (state_q)
      ARB: begin
        bus.in_ready = stray_s;
      end
      LOCK: begin
        bus.in_ready          = sel_s & {N{bus.out_ready}};
        bus.out_data          = g_data_s;
        bus.out_valid         = g_valid_s;
        bus.out_startofpacket = g_sop_s;
        bus.out_endofpacket   = g_eop_s;
        bus.out_empty         = g_empty_s;
        bus.out_channel       = g_q;
      end
      default: begin
        bus.in_ready = '0;
      end
    endcase
  end

  assign bus.sop_err = sop_err_q;

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
module tb_avalon_st_pkt_arbiter;
  localparam int N   = 4;
  localparam int DW  = 256;
  localparam int EW  = 5;
  localparam int CW  = 2;
  localparam int N3  = 3;
  localparam int DW3 = 32;
  localparam int EW3 = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  avalon_st_pkt_arbiter_if #(.N(N), .DATA_W(DW), .EMPTY_W(EW), .CH_W(CW)) bus4 ();
  avalon_st_pkt_arbiter_if #(.N(N3), .DATA_W(DW3), .EMPTY_W(EW3), .CH_W(CW)) bus3 ();

  avalon_st_pkt_arbiter #(.N(N), .DATA_W(DW), .EMPTY_W(EW), .CH_W(CW)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );
  avalon_st_pkt_arbiter #(.N(N3), .DATA_W(DW3), .EMPTY_W(EW3), .CH_W(CW)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  function automatic logic [DW-1:0] mk(input int s, input int b);
    logic [DW-1:0] d;
    d = '0;
    d[255:248] = 8'hA5;
    d[31:16] = s[15:0];
    d[15:0] = b[15:0];
    return d;
  endfunction

  function automatic logic [DW3-1:0] mk3(input int s, input int b);
    return {s[15:0], b[15:0]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic idle_all;
    bus4.in_data = '0; bus4.in_valid = '0; bus4.in_startofpacket = '0;
    bus4.in_endofpacket = '0; bus4.in_empty = '0; bus4.out_ready = 1'b1;
    bus3.in_data = '0; bus3.in_valid = '0; bus3.in_startofpacket = '0;
    bus3.in_endofpacket = '0; bus3.in_empty = '0; bus3.out_ready = 1'b1;
  endtask

  task automatic put4(input int s, input logic v, input logic sop, input logic eop,
                      input int b, input logic [EW-1:0] e);
    bus4.in_data[s*DW +: DW] = mk(s, b);
    bus4.in_valid[s] = v;
    bus4.in_startofpacket[s] = sop;
    bus4.in_endofpacket[s] = eop;
    bus4.in_empty[s*EW +: EW] = e;
  endtask

  task automatic put3(input int s, input logic v, input logic sop, input logic eop, input int b);
    bus3.in_data[s*DW3 +: DW3] = mk3(s, b);
    bus3.in_valid[s] = v;
    bus3.in_startofpacket[s] = sop;
    bus3.in_endofpacket[s] = eop;
    bus3.in_empty[s*EW3 +: EW3] = 2'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_all();
    step(); step();
    sample();
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", bus4.out_valid); end
    vectors++; if (bus4.in_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0000", bus4.in_ready); end
    vectors++; if (bus4.out_channel !== 2'd0) begin miscompares++; $display("FAIL reset_channel: got %0d want 0", bus4.out_channel); end
    vectors++; if (bus4.sop_err !== 1'b0) begin miscompares++; $display("FAIL reset_sop_err: got %0b want 0", bus4.sop_err); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single;
    put4(0, 1'b1, 1'b1, 1'b0, 0, 5'd0);
    sample();
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_bubble_valid: got %0b want 0", bus4.out_valid); end
    vectors++; if (bus4.in_ready !== 4'b0000) begin miscompares++; $display("FAIL single_bubble_ready: got %b want 0000", bus4.in_ready); end
    step();
    sample();
    vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_b0_valid: got %0b want 1", bus4.out_valid); end
    vectors++; if (bus4.out_channel !== 2'd0) begin miscompares++; $display("FAIL single_b0_channel: got %0d want 0", bus4.out_channel); end
    vectors++; if (bus4.out_data !== mk(0, 0)) begin miscompares++; $display("FAIL single_b0_data: got %0h want %0h", bus4.out_data, mk(0, 0)); end
    vectors++; if (bus4.out_startofpacket !== 1'b1) begin miscompares++; $display("FAIL single_b0_sop: got %0b want 1", bus4.out_startofpacket); end
    vectors++; if (bus4.in_ready !== 4'b0001) begin miscompares++; $display("FAIL single_b0_ready: got %b want 0001", bus4.in_ready); end
    step();
    put4(0, 1'b1, 1'b0, 1'b0, 1, 5'd0);
    sample();
    vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_b1_valid: got %0b want 1", bus4.out_valid); end
    vectors++; if (bus4.out_data !== mk(0, 1)) begin miscompares++; $display("FAIL single_b1_data: got %0h want %0h", bus4.out_data, mk(0, 1)); end
    step();
    put4(0, 1'b1, 1'b0, 1'b1, 2, 5'd5);
    sample();
    vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_b2_valid: got %0b want 1", bus4.out_valid); end
    vectors++; if (bus4.out_endofpacket !== 1'b1) begin miscompares++; $display("FAIL single_b2_eop: got %0b want 1", bus4.out_endofpacket); end
    vectors++; if (bus4.out_empty !== 5'd5) begin miscompares++; $display("FAIL single_b2_empty: got %0d want 5", bus4.out_empty); end
    vectors++; if (bus4.out_data !== mk(0, 2)) begin miscompares++; $display("FAIL single_b2_data: got %0h want %0h", bus4.out_data, mk(0, 2)); end
    step();
    // ptr is now 1: stream 1 must beat stream 0 in a tie.
    put4(0, 1'b1, 1'b1, 1'b1, 7, 5'd0);
    put4(1, 1'b1, 1'b1, 1'b1, 7, 5'd0);
    sample();
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_post_bubble: got %0b want 0", bus4.out_valid); end
    step();
    sample();
    vectors++; if (bus4.out_channel !== 2'd1) begin miscompares++; $display("FAIL single_ptr1_channel: got %0d want 1", bus4.out_channel); end
    step();
    put4(1, 1'b0, 1'b0, 1'b0, 0, 5'd0);
    sample();
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_tie_bubble: got %0b want 0", bus4.out_valid); end
    step();
    sample();
    vectors++; if (bus4.out_channel !== 2'd0) begin miscompares++; $display("FAIL single_tie_channel: got %0d want 0", bus4.out_channel); end
    step();
    idle_all();
  endtask

  task automatic test_fairness;
    int pos [N];
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    for (int i = 0; i < N; i++) put4(i, 1'b1, pos[i] == 0, pos[i] == 1, pos[i], 5'd0);
    for (int p = 0; p < 8; p++) begin
      int g;
      g = p % N;
      sample();
      vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL fair_bubble p%0d: got %0b want 0", p, bus4.out_valid); end
      step();
      sample();
      vectors++; if (bus4.out_channel !== g[CW-1:0]) begin miscompares++; $display("FAIL fair_sop_channel p%0d: got %0d want %0d", p, bus4.out_channel, g); end
      vectors++; if (bus4.out_data !== mk(g, 0) || bus4.out_startofpacket !== 1'b1) begin miscompares++; $display("FAIL fair_sop_beat p%0d: got %0h want %0h", p, bus4.out_data, mk(g, 0)); end
      step();
      pos[g] = 1;
      put4(g, 1'b1, 1'b0, 1'b1, 1, 5'd0);
      sample();
      vectors++; if (bus4.out_channel !== g[CW-1:0]) begin miscompares++; $display("FAIL fair_eop_channel p%0d: got %0d want %0d", p, bus4.out_channel, g); end
      vectors++; if (bus4.out_data !== mk(g, 1) || bus4.out_endofpacket !== 1'b1) begin miscompares++; $display("FAIL fair_eop_beat p%0d: got %0h want %0h", p, bus4.out_data, mk(g, 1)); end
      step();
      pos[g] = 0;
      put4(g, 1'b1, 1'b1, 1'b0, 0, 5'd0);
    end
    idle_all();
  endtask

  task automatic test_backpressure;
    logic pat [6];
    int b;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    b = 0;
    idle_all();
    put4(2, 1'b1, 1'b1, 1'b0, 0, 5'd0);
    sample();
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_bubble: got %0b want 0", bus4.out_valid); end
    step();
    for (int c = 0; c < 6; c++) begin
      bus4.out_ready = pat[c];
      put4(2, 1'b1, b == 0, b == 3, b, (b == 3) ? 5'd3 : 5'd0);
      sample();
      vectors++; if (bus4.in_ready !== {1'b0, pat[c], 2'b00}) begin miscompares++; $display("FAIL bp_in_ready c%0d: got %b want %b", c, bus4.in_ready, {1'b0, pat[c], 2'b00}); end
      vectors++; if (bus4.out_data !== mk(2, b)) begin miscompares++; $display("FAIL bp_data c%0d: got %0h want %0h", c, bus4.out_data, mk(2, b)); end
      vectors++; if (bus4.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid c%0d: got %0b want 1", c, bus4.out_valid); end
      step();
      if (pat[c]) b++;
    end
    idle_all();
    sample();
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %0b want 0", bus4.out_valid); end
    step();
  endtask

  task automatic test_stray;
    idle_all();
    put4(1, 1'b1, 1'b0, 1'b0, 9, 5'd0);
    sample();
    vectors++; if (bus4.in_ready !== 4'b0010) begin miscompares++; $display("FAIL stray_ready: got %b want 0010", bus4.in_ready); end
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL stray_valid: got %0b want 0", bus4.out_valid); end
    vectors++; if (bus4.sop_err !== 1'b0) begin miscompares++; $display("FAIL stray_err_early: got %0b want 0", bus4.sop_err); end
    step();
    idle_all();
    sample();
    vectors++; if (bus4.sop_err !== 1'b1) begin miscompares++; $display("FAIL stray_err_pulse: got %0b want 1", bus4.sop_err); end
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL stray_valid_after: got %0b want 0", bus4.out_valid); end
    step();
    sample();
    vectors++; if (bus4.sop_err !== 1'b0) begin miscompares++; $display("FAIL stray_err_clear: got %0b want 0", bus4.sop_err); end
    put4(0, 1'b1, 1'b0, 1'b0, 1, 5'd0);
    put4(3, 1'b1, 1'b0, 1'b0, 1, 5'd0);
    sample();
    vectors++; if (bus4.in_ready !== 4'b1001) begin miscompares++; $display("FAIL stray2_ready: got %b want 1001", bus4.in_ready); end
    step();
    idle_all();
    sample();
    vectors++; if (bus4.sop_err !== 1'b1) begin miscompares++; $display("FAIL stray2_err_pulse: got %0b want 1", bus4.sop_err); end
    step();
    sample();
    vectors++; if (bus4.sop_err !== 1'b0) begin miscompares++; $display("FAIL stray2_err_single: got %0b want 0", bus4.sop_err); end
    step();
  endtask

  task automatic test_reset_mid;
    idle_all();
    put4(3, 1'b1, 1'b1, 1'b0, 0, 5'd0);
    step();
    step();
    put4(3, 1'b1, 1'b0, 1'b0, 1, 5'd0);
    step();
    put4(3, 1'b1, 1'b0, 1'b0, 2, 5'd0);
    reset = 1'b1;
    sample();
    vectors++; if (bus4.out_channel !== 2'd3) begin miscompares++; $display("FAIL rmid_locked_channel: got %0d want 3", bus4.out_channel); end
    step();
    reset = 1'b0;
    idle_all();
    sample();
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %0b want 0", bus4.out_valid); end
    vectors++; if (bus4.out_channel !== 2'd0) begin miscompares++; $display("FAIL rmid_channel: got %0d want 0", bus4.out_channel); end
    vectors++; if (bus4.in_ready !== 4'b0000) begin miscompares++; $display("FAIL rmid_ready: got %b want 0000", bus4.in_ready); end
    put4(1, 1'b1, 1'b1, 1'b1, 5, 5'd0);
    put4(3, 1'b1, 1'b1, 1'b1, 6, 5'd0);
    step();
    sample();
    vectors++; if (bus4.out_channel !== 2'd1 || bus4.out_data !== mk(1, 5)) begin miscompares++; $display("FAIL rmid_first_grant: got ch %0d want 1", bus4.out_channel); end
    step();
    put4(1, 1'b0, 1'b0, 1'b0, 0, 5'd0);
    sample();
    vectors++; if (bus4.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_bubble: got %0b want 0", bus4.out_valid); end
    step();
    sample();
    vectors++; if (bus4.out_channel !== 2'd3 || bus4.out_data !== mk(3, 6)) begin miscompares++; $display("FAIL rmid_second_grant: got ch %0d want 3", bus4.out_channel); end
    step();
    idle_all();
  endtask

  task automatic test_wrap;
    reset = 1'b1;
    idle_all();
    step();
    reset = 1'b0;
    put3(1, 1'b1, 1'b1, 1'b1, 1);
    sample();
    vectors++; if (bus3.out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_bubble0: got %0b want 0", bus3.out_valid); end
    step();
    sample();
    vectors++; if (bus3.out_channel !== 2'd1) begin miscompares++; $display("FAIL wrap_setup_channel: got %0d want 1", bus3.out_channel); end
    step();
    put3(1, 1'b0, 1'b0, 1'b0, 0);
    put3(0, 1'b1, 1'b1, 1'b1, 10);
    put3(2, 1'b1, 1'b1, 1'b1, 20);
    step();
    sample();
    vectors++; if (bus3.out_channel !== 2'd2 || bus3.out_data !== mk3(2, 20)) begin miscompares++; $display("FAIL wrap_grant2: got ch %0d data %0h want 2 %0h", bus3.out_channel, bus3.out_data, mk3(2, 20)); end
    step();
    put3(2, 1'b0, 1'b0, 1'b0, 0);
    sample();
    vectors++; if (bus3.out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_bubble1: got %0b want 0", bus3.out_valid); end
    step();
    sample();
    vectors++; if (bus3.out_channel !== 2'd0 || bus3.out_data !== mk3(0, 10)) begin miscompares++; $display("FAIL wrap_grant0: got ch %0d data %0h want 0 %0h", bus3.out_channel, bus3.out_data, mk3(0, 10)); end
    step();
    idle_all();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_stray();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end want end");
    $fatal(1, "watchdog");
  end
endmodule
